// File: rtl/vec_lane_sequencer_pkg.sv
// vec_seq_pkg: sequencer states and ALU opcodes
package vec_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
endpackage

// File: rtl/vec_lane_sequencer_elem_select.sv
// vec_elem_select: extracts lane idx from a packed element vector
module vec_elem_select #(
  parameter int WIDTH = 3,
  parameter int LANES = 4
) (
  input  logic [LANES*(WIDTH+1)-1:0] vec,
  input  logic [$clog2(LANES)-1:0]   idx,
  output logic [WIDTH:0]             elem
);
  localparam int IW = $clog2(LANES);
  always_comb begin
    elem = '0;
    for (int i = 0; i < LANES; i++) elem = (idx == IW'(i)) ? vec[i*(WIDTH+1) +: WIDTH+1] : elem;
  end
endmodule

// File: rtl/vec_lane_sequencer.sv
// vec_lane_sequencer: streams vector lanes through a shared scalar ALU and reassembles the result
module vec_lane_sequencer
  import vec_seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int LANES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*(WIDTH+1)-1:0] vec_a,
  input  logic [LANES*(WIDTH+1)-1:0] vec_b,
  input  logic [1:0]                 op,
  input  logic                       ci,
  output logic [WIDTH:0]             alu_a,
  output logic [WIDTH:0]             alu_b,
  output logic [1:0]                 alu_op,
  output logic                       alu_ci,
  input  logic [WIDTH:0]             alu_out,
  input  logic                       alu_cero,
  input  logic                       alu_negativo,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*(WIDTH+1)-1:0] vec_out,
  output logic [LANES-1:0]           cero_mask,
  output logic [LANES-1:0]           neg_mask,
  output logic                       all_zero
);
  localparam int IW = $clog2(LANES);
  localparam int E = WIDTH + 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [LANES*E-1:0] opa, opb;
  logic [1:0] opr;
  logic cir;
  logic [WIDTH:0] ela, elb;
  vec_elem_select #(.WIDTH(WIDTH), .LANES(LANES)) sel_a (.vec(opa), .idx(idx), .elem(ela));
  vec_elem_select #(.WIDTH(WIDTH), .LANES(LANES)) sel_b (.vec(opb), .idx(idx), .elem(elb));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      opa <= '0;
      opb <= '0;
      opr <= '0;
      cir <= 1'b0;
      vec_out <= '0;
      cero_mask <= '0;
      neg_mask <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        opa <= vec_a;
        opb <= vec_b;
        opr <= op;
        cir <= ci;
        idx <= '0;
        vec_out <= '0;
        cero_mask <= '0;
        neg_mask <= '0;
      end
      if (state == RUN) begin
        for (int i = 0; i < LANES; i++)
          if (idx == IW'(i)) begin
            vec_out[i*E +: E] <= alu_out;
            cero_mask[i] <= alu_cero;
            neg_mask[i] <= alu_negativo;
          end
        idx <= (idx == LAST) ? idx : idx + IW'(1);
      end
    end
  end
  always_comb begin
    nxt = (state == IDLE) ? (in_valid ? RUN : IDLE) :
          (state == RUN)  ? ((idx == LAST) ? DONE : RUN) :
          (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    all_zero = out_valid && &cero_mask;
    alu_a = (state == RUN) ? ela : '0;
    alu_b = (state == RUN) ? elb : '0;
    alu_op = (state == RUN) ? opr : 2'b00;
    alu_ci = (state == RUN) && cir;
  end
endmodule

// File: tb/tb_vec_lane_sequencer.sv
// tb_vec_lane_sequencer: scoreboard bench with a behavioural 4-op ALU attached
module tb_vec_lane_sequencer;
  import vec_seq_pkg::*;
  localparam int W = 3, L = 4, E = W + 1, VW = L * E;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, ci = 0;
  logic in_ready, out_valid, all_zero, alu_ci, alu_cero, alu_negativo;
  logic [VW-1:0] vec_a = '0, vec_b = '0, vec_out;
  logic [1:0] op = 2'b00, alu_op;
  logic [W:0] alu_a, alu_b, alu_out;
  logic [L-1:0] cero_mask, neg_mask;
  typedef struct {logic [VW-1:0] v; logic [L-1:0] c; logic [L-1:0] n;} exp_t;
  exp_t sbq[$];
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  vec_lane_sequencer #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .vec_a(vec_a), .vec_b(vec_b), .op(op), .ci(ci),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_cero(alu_cero), .alu_negativo(alu_negativo),
    .out_valid(out_valid), .out_ready(out_ready), .vec_out(vec_out),
    .cero_mask(cero_mask), .neg_mask(neg_mask), .all_zero(all_zero)
  );
  logic [E:0] t;
  always_comb begin
    t = '0;
    case (alu_op)
      OP_ADD: t = {1'b0, alu_a} + {1'b0, alu_b} + (E+1)'(alu_ci);
      OP_MUL: t = (E+1)'({1'b0, alu_a} * {1'b0, alu_b});
      OP_DIV: t = (alu_b == '0) ? '1 : {1'b0, alu_a} / {1'b0, alu_b};
      default: t = {1'b0, alu_a} - {1'b0, alu_b} - (E+1)'(alu_ci);
    endcase
    alu_negativo = (alu_op == OP_SUB) && ({1'b0, alu_a} < {1'b0, alu_b} + (E+1)'(alu_ci));
    alu_out = alu_negativo ? '0 : t[W:0];
    alu_cero = alu_out == '0;
  end
  function automatic logic [VW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction
  task automatic drive(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] o, input logic c);
    vec_a = a;
    vec_b = b;
    op = o;
    ci = c;
    in_valid = 1;
  endtask
  task automatic accept(output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      if (lat < 0) begin
        @(posedge clk); #1;
        if (out_valid) lat = k;
      end
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    checks++;
    if ({in_ready, out_valid, all_zero} !== 3'b100) begin
      fails++;
      $display("FAIL reset_hs: {in_ready,out_valid,all_zero}=%b expected 100", {in_ready, out_valid, all_zero});
    end
    checks++;
    if ({vec_out, cero_mask, neg_mask} !== '0) begin
      fails++;
      $display("FAIL reset_out: vec_out=%h cero=%b neg=%b expected all 0", vec_out, cero_mask, neg_mask);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_ci} !== '0) begin
      fails++;
      $display("FAIL reset_alu: a=%h b=%h op=%b ci=%b expected 0", alu_a, alu_b, alu_op, alu_ci);
    end
  endtask
  task automatic test_arith;
    logic [VW-1:0] ta[3], tb[3], tv[3];
    logic [1:0] to[3];
    logic [L-1:0] tc[3], tn[3];
    exp_t e;
    int lat;
    ta[0] = pk(1, 2, 3, 4);  tb[0] = pk(1, 1, 1, 1); to[0] = OP_ADD; tv[0] = pk(2, 3, 4, 5); tc[0] = 4'b0000; tn[0] = 4'b0000;
    ta[1] = pk(5, 3, 2, 7);  tb[1] = pk(3, 3, 5, 1); to[1] = OP_SUB; tv[1] = pk(2, 0, 0, 6); tc[1] = 4'b0110; tn[1] = 4'b0100;
    ta[2] = pk(15, 0, 0, 0); tb[2] = pk(1, 0, 0, 0); to[2] = OP_ADD; tv[2] = pk(0, 0, 0, 0); tc[2] = 4'b1111; tn[2] = 4'b0000;
    out_ready = 1;
    for (int j = 0; j < 3; j++) begin
      sbq.push_back('{v: tv[j], c: tc[j], n: tn[j]});
      drive(ta[j], tb[j], to[j], 1'b0);
      accept(lat);
      checks++;
      if (lat !== 4) begin
        fails++;
        $display("FAIL arith%0d_latency: %0d edges expected 4", j, lat);
      end
      e = sbq.pop_front();
      checks++;
      if ({vec_out, cero_mask, neg_mask} !== {e.v, e.c, e.n}) begin
        fails++;
        $display("FAIL arith%0d_result: vec=%h cero=%b neg=%b expected vec=%h cero=%b neg=%b", j, vec_out, cero_mask, neg_mask, e.v, e.c, e.n);
      end
      checks++;
      if (all_zero !== &e.c) begin
        fails++;
        $display("FAIL arith%0d_all_zero: %b expected %b", j, all_zero, &e.c);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        fails++;
        $display("FAIL arith%0d_drain: {out_valid,in_ready}=%b expected 01", j, {out_valid, in_ready});
      end
    end
  endtask
  task automatic test_backpressure;
    exp_t e;
    int lat;
    out_ready = 0;
    sbq.push_back('{v: pk(2, 3, 4, 5), c: 4'b0000, n: 4'b0000});
    drive(pk(1, 2, 3, 4), pk(1, 1, 1, 1), OP_ADD, 1'b0);
    accept(lat);
    checks++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL bp_latency: %0d edges expected 4", lat);
    end
    drive(pk(5, 3, 2, 7), pk(3, 3, 5, 1), OP_SUB, 1'b0);
    e = sbq[0];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, vec_out, cero_mask, neg_mask} !== {2'b10, e.v, e.c, e.n}) begin
        fails++;
        $display("FAIL bp_hold%0d: ov=%b ir=%b vec=%h cero=%b neg=%b expected ov=1 ir=0 vec=%h", k, out_valid, in_ready, vec_out, cero_mask, neg_mask, e.v);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    void'(sbq.pop_front());
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: {out_valid,in_ready}=%b expected 01", {out_valid, in_ready});
    end
    sbq.push_back('{v: pk(2, 0, 0, 6), c: 4'b0110, n: 4'b0100});
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_second_accept: in_ready=%b expected 0", in_ready);
    end
    lat = -1;
    for (int k = 1; k <= 12; k++)
      if (lat < 0) begin
        @(posedge clk); #1;
        if (out_valid) lat = k;
      end
    e = sbq.pop_front();
    checks++;
    if (lat !== 4 || {vec_out, cero_mask, neg_mask} !== {e.v, e.c, e.n}) begin
      fails++;
      $display("FAIL bp_second_result: lat=%0d vec=%h cero=%b neg=%b expected lat=4 vec=%h cero=%b neg=%b", lat, vec_out, cero_mask, neg_mask, e.v, e.c, e.n);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_run;
    bit seen = 0;
    out_ready = 1;
    drive(pk(2, 3, 1, 2), pk(3, 2, 2, 2), OP_MUL, 1'b0);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({alu_a, alu_b, alu_op} !== {4'd1, 4'd2, OP_MUL}) begin
      fails++;
      $display("FAIL run_lane2_alu: a=%0d b=%0d op=%b expected a=1 b=2 op=01", alu_a, alu_b, alu_op);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if ({in_ready, out_valid, all_zero, vec_out, cero_mask, neg_mask} !== {3'b100, {(VW + 2 * L){1'b0}}}) begin
      fails++;
      $display("FAIL abort_state: ir=%b ov=%b az=%b vec=%h cero=%b neg=%b expected ir=1 rest 0", in_ready, out_valid, all_zero, vec_out, cero_mask, neg_mask);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_ci} !== '0) begin
      fails++;
      $display("FAIL abort_alu: a=%h b=%h op=%b ci=%b expected 0", alu_a, alu_b, alu_op, alu_ci);
    end
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_result: out_valid seen=%b expected 0", seen);
    end
  endtask
  task automatic test_back_to_back;
    exp_t e1, e2, e;
    int nacc = 0, ndrn = 0;
    int tacc[2];
    bit acc, drn;
    e1 = '{v: pk(2, 3, 4, 5), c: 4'b0000, n: 4'b0000};
    e2 = '{v: pk(6, 1, 8, 15), c: 4'b0000, n: 4'b0000};
    out_ready = 1;
    drive(pk(1, 2, 3, 4), pk(1, 1, 1, 1), OP_ADD, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (nacc < 2 || ndrn < 2) begin
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (acc) sbq.push_back(nacc == 0 ? e1 : e2);
        if (drn) begin
          checks++;
          if (sbq.size() == 0) begin
            fails++;
            $display("FAIL b2b_unexpected: result %h with empty scoreboard", vec_out);
          end else begin
            e = sbq.pop_front();
            if ({vec_out, cero_mask, neg_mask} !== {e.v, e.c, e.n}) begin
              fails++;
              $display("FAIL b2b_result%0d: vec=%h cero=%b neg=%b expected vec=%h cero=%b neg=%b", ndrn, vec_out, cero_mask, neg_mask, e.v, e.c, e.n);
            end
          end
          ndrn++;
        end
        @(posedge clk); #1;
        if (acc) begin
          tacc[nacc] = i;
          nacc++;
          if (nacc == 1) drive(pk(3, 1, 4, 7), pk(3, 0, 4, 8), OP_ADD, 1'b0);
          else in_valid = 0;
        end
      end
    end
    in_valid = 0;
    checks++;
    if (nacc !== 2 || ndrn !== 2) begin
      fails++;
      $display("FAIL b2b_count: accepts=%0d drains=%0d expected 2 and 2", nacc, ndrn);
    end else begin
      checks++;
      if (tacc[1] - tacc[0] !== 6) begin
        fails++;
        $display("FAIL b2b_spacing: %0d cycles expected 6", tacc[1] - tacc[0]);
      end
    end
  endtask
  initial begin
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/vec_lane_sequencer.md
Name: vec_lane_sequencer

Overview:
- Upstream/downstream companion to the scalar 4-op ALU (add/mul/div/sub, with zero and negative flags).
- Accepts a packed operand vector pair over a valid/ready handshake and streams one element per cycle into a single shared combinational ALU.
- Captures each element result and its flags, then presents the assembled result vector and per-lane flag masks on an output valid/ready handshake.
- Sits between the vector register-read stage and writeback in the vector datapath.

Parameters:
- WIDTH, 3: element MSB index; each element is WIDTH+1 bits, matching the ALU `[WIDTH:0]` convention.
- LANES, 4: number of elements per vector, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand vector offered.
- in_ready  out  1  sequencer can accept a vector.
- vec_a  in  LANES*(WIDTH+1)  packed operand A; lane i at bits `[i*(WIDTH+1) +: WIDTH+1]`.
- vec_b  in  LANES*(WIDTH+1)  packed operand B, same packing as vec_a.
- op  in  2  opcode: 00 add, 01 mul, 10 div, 11 sub.
- ci  in  1  carry-in, applied to every lane.
- alu_a  out  WIDTH+1  element A to the ALU.
- alu_b  out  WIDTH+1  element B to the ALU.
- alu_op  out  2  opcode to the ALU.
- alu_ci  out  1  carry-in to the ALU.
- alu_out  in  WIDTH+1  ALU result.
- alu_cero  in  1  ALU zero flag.
- alu_negativo  in  1  ALU negative flag.
- out_valid  out  1  result vector available.
- out_ready  in  1  consumer accepts the result.
- vec_out  out  LANES*(WIDTH+1)  packed results, same packing as the inputs.
- cero_mask  out  LANES  bit i = zero flag of lane i.
- neg_mask  out  LANES  bit i = negative flag of lane i.
- all_zero  out  1  AND of cero_mask, valid only while out_valid=1.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at an edge):
  - state becomes IDLE and the lane index becomes 0.
  - out_valid=0, vec_out=0, cero_mask=0, neg_mask=0, all_zero=0.
  - The operand registers are cleared.
  - Reset takes priority over every other event.
- Reset during RUN or DONE aborts the vector: no out_valid pulse occurs and no partial result is presented.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch vec_a, vec_b, op and ci; set idx=0; clear the result and mask registers; go to RUN.
- RUN:
  - in_ready=0.
  - alu_a/alu_b are lane idx of the latched operands (combinational from registers); alu_op/alu_ci are the latched values.
  - Each edge writes alu_out, alu_cero and alu_negativo into lane idx, then increments idx.
  - At idx==LANES-1 the capture completes the vector and the state goes to DONE.
- DONE:
  - out_valid=1; vec_out, the masks and all_zero are stable.
  - On out_ready at an edge, go to IDLE and drop out_valid.
  - in_ready=0 in DONE; a new vector is not accepted in the same cycle as the drain.
- Outside RUN, alu_a, alu_b, alu_op and alu_ci are driven 0.
- Latency: out_valid is asserted exactly LANES edges after the accepting edge.
- Minimum spacing between accepted vectors is LANES+2 cycles.
- in_valid while in_ready=0 is ignored; upstream holds its data until the handshake completes.
- Arithmetic (overflow, divide-by-zero, negative-to-zero clamp) is entirely the ALU's. Results are stored verbatim at WIDTH+1 bits with no extension or truncation by this block.
- idx register width is `$clog2(LANES)`; idx never exceeds LANES-1 and does not wrap inside RUN.

Decomposition:
- Package vec_seq_pkg holds:
  - the state enum `{IDLE, RUN, DONE}`;
  - opcode constants OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_SUB=2'b11.
- One sub-module, vec_elem_select: a parameterized WIDTH/LANES mux that extracts lane idx from a packed vector, instantiated twice (A and B).
- The capture write-enable decode stays in the top module.

Test Plan (WIDTH=3, LANES=4, real ALU attached; lanes listed 0..3):
- Add: A={1,2,3,4}, B={1,1,1,1}, op=00, ci=0, out_ready=1 -> out_valid 4 edges after accept, vec_out={2,3,4,5}, cero_mask=0000, neg_mask=0000, all_zero=0.
- Sub: A={5,3,2,7}, B={3,3,5,1}, op=11, ci=0 -> vec_out={2,0,0,6}, cero_mask=0110 (lanes 1,2), neg_mask=0100 (lane 2).
- Add wrap: A={15,0,0,0}, B={1,0,0,0}, op=00 -> vec_out={0,0,0,0}, cero_mask=1111, all_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0. A second in_valid in that window is ignored. Raise out_ready -> IDLE next edge, then the second vector is accepted.
- Reset mid-RUN: assert rst at lane 2 of a mul vector -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0, and no result appears later.
- Back-to-back: two vectors with in_valid held high and out_ready=1 -> accepts spaced exactly 6 cycles apart, each result correct.
